// File: rtl/upct_if.sv
// Upper PC table bus: fetch read port and
// branch-resolution update port with response.
interface upct_if #(
  parameter int LOG_UPCT_ENTRIES = 3,
  parameter int UPPER_WIDTH = 26,
  parameter int LANE_WIDTH = 3
);
  localparam int UPC_WIDTH = UPPER_WIDTH + LANE_WIDTH;

  logic                        read_valid_in;
  logic [LOG_UPCT_ENTRIES-1:0] read_index_in;
  logic [UPC_WIDTH-1:0]        read_upc_out;
  logic                        update0_valid_in;
  logic [37:0]                 update0_target_in;
  logic                        update1_valid_out;
  logic [LOG_UPCT_ENTRIES-1:0] update1_upct_index_out;
  logic                        update1_hit_out;

  modport master (
    output read_valid_in, read_index_in,
    output update0_valid_in, update0_target_in,
    input  read_upc_out,
    input  update1_valid_out, update1_upct_index_out,
    input  update1_hit_out
  );

  modport slave (
    input  read_valid_in, read_index_in,
    input  update0_valid_in, update0_target_in,
    output read_upc_out,
    output update1_valid_out, update1_upct_index_out,
    output update1_hit_out
  );
endinterface

// File: rtl/upct.sv
// Upper PC table: 8 UPC entries, 1-cycle read,
// match-or-allocate update with tree-PLRU victim.
module upct #(
  parameter int UPCT_ENTRIES = 8,
  parameter int LOG_UPCT_ENTRIES = 3,
  parameter int UPPER_WIDTH = 26,
  parameter int LANE_WIDTH = 3
) (
  input logic CLK,
  input logic nRST,
  upct_if.slave bus
);
  localparam int UW = UPPER_WIDTH + LANE_WIDTH;
  localparam int IW = LOG_UPCT_ENTRIES;

  logic [UW-1:0] upct_array [UPCT_ENTRIES];
  logic [6:0]    plru;
  logic [6:0]    plru_next;
  logic [UW-1:0] upc;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] victim;
  logic [IW-1:0] idx;
  logic [2:0]    leaf;
  logic          alloc;

  // Bits [11:3] live in the BTB small target
  assign upc = {bus.update0_target_in[37:38-UPPER_WIDTH],
                bus.update0_target_in[LANE_WIDTH-1:0]};

  // Lowest matching entry wins on duplicates
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = UPCT_ENTRIES - 1; i >= 0; i--) begin
      if (upct_array[i] == upc) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Walk the tree: 0 = lower side, 1 = upper side
  always_comb begin
    victim[2] = plru[0];
    victim[1] = victim[2] ? plru[2] : plru[1];
    victim[0] = plru[3'd3 + {1'b0, victim[2:1]}];
  end

  assign idx = hit ? hit_idx : victim;
  assign alloc = bus.update0_valid_in && !hit;
  assign leaf = 3'd3 + {1'b0, idx[2:1]};

  // Touch: point every node on the path away from idx
  always_comb begin
    plru_next = plru;
    plru_next[0] = ~idx[2];
    if (idx[2]) plru_next[2] = ~idx[1];
    else        plru_next[1] = ~idx[1];
    plru_next[leaf] = ~idx[0];
  end

  // Array write on allocation and PLRU update
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < UPCT_ENTRIES; i++)
        upct_array[i] <= '0;
      plru <= '0;
    end else if (bus.update0_valid_in) begin
      if (!hit) upct_array[victim] <= upc;
      plru <= plru_next;
    end
  end

  // Read port, write-first against a same-cycle allocation
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.read_upc_out <= '0;
    end else if (bus.read_valid_in) begin
      if (alloc && victim == bus.read_index_in)
        bus.read_upc_out <= upc;
      else
        bus.read_upc_out <= upct_array[bus.read_index_in];
    end
  end

  // Update response, one cycle after the request
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.update1_valid_out <= 1'b0;
      bus.update1_upct_index_out <= '0;
      bus.update1_hit_out <= 1'b0;
    end else begin
      bus.update1_valid_out <= bus.update0_valid_in;
      if (bus.update0_valid_in) begin
        bus.update1_upct_index_out <= idx;
        bus.update1_hit_out <= hit;
      end
    end
  end
endmodule
